// File: rtl/ddr2_refresh_pkg.sv
// Shared definitions for the DDR2 multi-rank refresh monitor: command
// encodings on {ras#, cas#, we#}, debt width and the saturating debt step.
package ddr2_refresh_pkg;

  localparam int DEBT_W = 5;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_REF = 3'b001;

  typedef logic signed [DEBT_W-1:0] debt_t;

  // What the debt counter does in a given cycle.
  typedef enum logic [1:0] {
    DEBT_HOLD = 2'b00,
    DEBT_INC  = 2'b01,
    DEBT_DEC  = 2'b10
  } debt_op_e;

  function automatic debt_op_e debt_op(input logic tick, input logic refresh);
    if (tick && !refresh) return DEBT_INC;
    if (refresh && !tick) return DEBT_DEC;
    return DEBT_HOLD;
  endfunction

  // One debt step clamped to [-max_neg, +max_pos]; out-of-range values are never produced.
  function automatic debt_t debt_step(input debt_t cur, input debt_op_e op,
                                      input int max_pos, input int max_neg);
    debt_t nxt;
    nxt = cur;
    if (op == DEBT_INC && int'(cur) < max_pos) nxt = cur + debt_t'(1);
    if (op == DEBT_DEC && int'(cur) > -max_neg) nxt = cur - debt_t'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/ddr2_multirank_refresh_monitor_if.sv
// Pad-side command pins plus monitor status outputs.
interface ddr2_multirank_refresh_monitor_if #(
  parameter int NUM_RANKS = 2
);
  import ddr2_refresh_pkg::*;

  logic                        ready_i;
  logic [NUM_RANKS-1:0]        cke_pad;
  logic [NUM_RANKS-1:0]        csbar_pad;
  logic                        rasbar_pad;
  logic                        casbar_pad;
  logic                        webar_pad;
  logic [NUM_RANKS*DEBT_W-1:0] debt_o;
  logic [NUM_RANKS-1:0]        err_starve_o;
  logic [NUM_RANKS-1:0]        err_pullin_o;
  logic [NUM_RANKS-1:0]        err_trfc_o;
  logic [31:0]                 ref_count_o;

  modport master (
    output ready_i, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad,
    input  debt_o, err_starve_o, err_pullin_o, err_trfc_o, ref_count_o
  );

  modport slave (
    input  ready_i, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad,
    output debt_o, err_starve_o, err_pullin_o, err_trfc_o, ref_count_o
  );

endinterface

// File: rtl/ddr2_refresh_rank_tracker.sv
// Per-rank refresh bookkeeping: signed debt, tRFC window and sticky errors.
module ddr2_refresh_rank_tracker
  import ddr2_refresh_pkg::*;
#(
  parameter int TRFC_CLK     = 105,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  enable,
  input  logic  tick,
  input  logic  ref_cmd,
  input  logic  cmd_valid,
  output debt_t debt,
  output logic  err_starve,
  output logic  err_pullin,
  output logic  err_trfc
);

  localparam int TW = (TRFC_CLK > 1) ? $clog2(TRFC_CLK) : 1;
  localparam logic [TW-1:0] TRFC_LOAD = TW'(TRFC_CLK - 1);

  logic [TW-1:0] trfc_cnt;
  debt_t         debt_nxt;
  logic          starve_hit;
  logic          pullin_hit;
  logic          trfc_hit;

  // Next debt and the error conditions seen this cycle.
  always_comb begin
    debt_nxt   = debt_step(debt, debt_op(tick, ref_cmd), MAX_POSTPONE + 1, MAX_PULLIN);
    starve_hit = (int'(debt_nxt) == MAX_POSTPONE + 1);
    pullin_hit = ref_cmd && !tick && (int'(debt) == -MAX_PULLIN);
    trfc_hit   = cmd_valid && (trfc_cnt != '0);
  end

  // Debt and tRFC window reset to zero while disabled; error flags only clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      debt       <= '0;
      trfc_cnt   <= '0;
      err_starve <= 1'b0;
      err_pullin <= 1'b0;
      err_trfc   <= 1'b0;
    end else if (!enable) begin
      debt     <= '0;
      trfc_cnt <= '0;
    end else begin
      debt <= debt_nxt;
      if (ref_cmd)              trfc_cnt <= TRFC_LOAD;
      else if (trfc_cnt != '0)  trfc_cnt <= trfc_cnt - TW'(1);
      if (starve_hit) err_starve <= 1'b1;
      if (pullin_hit) err_pullin <= 1'b1;
      if (trfc_hit)   err_trfc   <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_multirank_refresh_monitor.sv
// Watches DDR2 command pins across ranks: shared tREFI credit tick, per-rank
// refresh debt / tRFC checking, and a global count of accepted refreshes.
module ddr2_multirank_refresh_monitor
  import ddr2_refresh_pkg::*;
#(
  parameter int NUM_RANKS    = 2,
  parameter int TREFI_CLK    = 7800,
  parameter int TRFC_CLK     = 105,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8
) (
  input logic clk,
  input logic reset,
  ddr2_multirank_refresh_monitor_if.slave mon
);

  localparam int IW = $clog2(TREFI_CLK);

  logic [IW-1:0]               int_cnt;
  logic                        tick;
  logic [2:0]                  cmd;
  logic [NUM_RANKS-1:0]        ref_vec;
  logic [NUM_RANKS-1:0]        nonnop_vec;
  logic [31:0]                 ref_pop;
  logic [31:0]                 ref_count;
  debt_t                       debt_arr   [NUM_RANKS];
  logic                        starve_arr [NUM_RANKS];
  logic                        pullin_arr [NUM_RANKS];
  logic                        trfc_arr   [NUM_RANKS];
  logic [NUM_RANKS*DEBT_W-1:0] debt_bus;
  logic [NUM_RANKS-1:0]        starve_bus;
  logic [NUM_RANKS-1:0]        pullin_bus;
  logic [NUM_RANKS-1:0]        trfc_bus;

  assign cmd  = {mon.rasbar_pad, mon.casbar_pad, mon.webar_pad};
  assign tick = mon.ready_i && (int_cnt == IW'(TREFI_CLK - 1));

  // Per-rank command decode and refresh popcount.
  always_comb begin
    ref_vec    = '0;
    nonnop_vec = '0;
    ref_pop    = '0;
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      ref_vec[r]    = mon.cke_pad[r] && !mon.csbar_pad[r] && (cmd == CMD_REF);
      nonnop_vec[r] = !mon.csbar_pad[r] && (cmd != CMD_NOP);
      ref_pop       = ref_pop + 32'(ref_vec[r]);
    end
  end

  // Interval counter: held at 0 while not ready so the first tick lands TREFI_CLK cycles after ready.
  always_ff @(posedge clk) begin
    if (reset || !mon.ready_i) int_cnt <= '0;
    else if (tick)             int_cnt <= '0;
    else                       int_cnt <= int_cnt + IW'(1);
  end

  // Total accepted refreshes; retained while not ready.
  always_ff @(posedge clk) begin
    if (reset)            ref_count <= '0;
    else if (mon.ready_i) ref_count <= ref_count + ref_pop;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RANKS; g++) begin : g_rank
      ddr2_refresh_rank_tracker #(
        .TRFC_CLK     (TRFC_CLK),
        .MAX_POSTPONE (MAX_POSTPONE),
        .MAX_PULLIN   (MAX_PULLIN)
      ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .enable     (mon.ready_i),
        .tick       (tick),
        .ref_cmd    (ref_vec[g]),
        .cmd_valid  (nonnop_vec[g]),
        .debt       (debt_arr[g]),
        .err_starve (starve_arr[g]),
        .err_pullin (pullin_arr[g]),
        .err_trfc   (trfc_arr[g])
      );
    end
  endgenerate

  // Pack per-rank registered state onto the output buses.
  always_comb begin
    debt_bus   = '0;
    starve_bus = '0;
    pullin_bus = '0;
    trfc_bus   = '0;
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      debt_bus[r*DEBT_W +: DEBT_W] = debt_arr[r];
      starve_bus[r]                = starve_arr[r];
      pullin_bus[r]                = pullin_arr[r];
      trfc_bus[r]                  = trfc_arr[r];
    end
  end

  assign mon.debt_o       = debt_bus;
  assign mon.err_starve_o = starve_bus;
  assign mon.err_pullin_o = pullin_bus;
  assign mon.err_trfc_o   = trfc_bus;
  assign mon.ref_count_o  = ref_count;

endmodule

// File: tb/tb_ddr2_multirank_refresh_monitor.sv
// Directed bench for the refresh monitor: a short per-cycle vector table
// plus multi-interval sequences for starvation, pull-in, tRFC and ready gating.
module tb_ddr2_multirank_refresh_monitor;

  localparam int TREFI = 2000;
  localparam int TRFC  = 105;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_ACT = 3'b011;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ddr2_multirank_refresh_monitor_if #(.NUM_RANKS(2)) bus ();

  ddr2_multirank_refresh_monitor #(
    .NUM_RANKS    (2),
    .TREFI_CLK    (TREFI),
    .TRFC_CLK     (TRFC),
    .MAX_POSTPONE (8),
    .MAX_PULLIN   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [1:0] cke;
    logic [1:0] cs;
    logic [2:0] cmd;
    int         d0;
    int         d1;
    logic [1:0] trfc;
    int         cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int debt_of(input int r);
    logic signed [4:0] v;
    v = bus.debt_o[5*r +: 5];
    return int'(v);
  endfunction

  task automatic cyc(input logic rdy, input logic [1:0] cke, input logic [1:0] cs,
                     input logic [2:0] cmd);
    bus.ready_i    = rdy;
    bus.cke_pad    = cke;
    bus.csbar_pad  = cs;
    bus.rasbar_pad = cmd[2];
    bus.casbar_pad = cmd[1];
    bus.webar_pad  = cmd[0];
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 2'b11, 2'b11, C_NOP);
  endtask

  // Reset cycle with ready high and refreshes on both ranks: reset must win.
  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 2'b11, 2'b00, C_REF);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_debt"},   longint'(bus.debt_o), 0);
    chk({tag, "_starve"}, longint'(bus.err_starve_o), 0);
    chk({tag, "_pullin"}, longint'(bus.err_pullin_o), 0);
    chk({tag, "_trfc"},   longint'(bus.err_trfc_o), 0);
    chk({tag, "_count"},  longint'(bus.ref_count_o), 0);
  endtask

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    reset  = 1'b0;

    //            rdy   cke    cs     cmd    d0  d1  trfc   cnt
    vecs[0] = '{1'b0, 2'b11, 2'b00, C_REF,  0,  0, 2'b00, 0};
    vecs[1] = '{1'b1, 2'b11, 2'b10, C_REF, -1,  0, 2'b00, 1};
    vecs[2] = '{1'b1, 2'b11, 2'b01, C_ACT, -1,  0, 2'b00, 1};
    vecs[3] = '{1'b1, 2'b11, 2'b00, C_REF, -2, -1, 2'b01, 3};
    vecs[4] = '{1'b1, 2'b01, 2'b00, C_REF, -3, -1, 2'b11, 4};
    vecs[5] = '{1'b0, 2'b11, 2'b11, C_NOP,  0,  0, 2'b11, 4};
    vecs[6] = '{1'b0, 2'b11, 2'b00, C_REF,  0,  0, 2'b11, 4};
    vecs[7] = '{1'b1, 2'b11, 2'b11, C_REF,  0,  0, 2'b11, 4};

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Per-cycle vector table
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rdy, vecs[i].cke, vecs[i].cs, vecs[i].cmd);
      chk($sformatf("vec%0d_debt0", i), debt_of(0), vecs[i].d0);
      chk($sformatf("vec%0d_debt1", i), debt_of(1), vecs[i].d1);
      chk($sformatf("vec%0d_trfc", i), longint'(bus.err_trfc_o), longint'(vecs[i].trfc));
      chk($sformatf("vec%0d_count", i), longint'(bus.ref_count_o), vecs[i].cnt);
      chk($sformatf("vec%0d_starve_pullin", i),
          longint'({bus.err_starve_o, bus.err_pullin_o}), 0);
    end

    // tRFC: ACTIVATE at +104 is a violation
    do_reset();
    cyc(1'b1, 2'b11, 2'b10, C_REF);
    nop(TRFC - 2);
    chk("trfc_before_act", longint'(bus.err_trfc_o), 0);
    cyc(1'b1, 2'b11, 2'b10, C_ACT);
    chk("trfc_act_104", longint'(bus.err_trfc_o), 1);

    // tRFC: ACTIVATE at +105 is legal
    do_reset();
    cyc(1'b1, 2'b11, 2'b10, C_REF);
    nop(TRFC - 1);
    cyc(1'b1, 2'b11, 2'b10, C_ACT);
    chk("trfc_act_105", longint'(bus.err_trfc_o), 0);

    // tRFC window is per rank; then reset mid-window with an error set
    do_reset();
    cyc(1'b1, 2'b11, 2'b10, C_REF);
    nop(9);
    cyc(1'b1, 2'b11, 2'b01, C_ACT);
    chk("trfc_other_rank", longint'(bus.err_trfc_o), 0);
    cyc(1'b1, 2'b11, 2'b10, C_ACT);
    chk("trfc_same_rank_11", longint'(bus.err_trfc_o), 1);
    do_reset();
    chk_all_zero("reset_mid_trfc");
    nop(1);
    cyc(1'b1, 2'b11, 2'b10, C_ACT);
    chk("no_trfc_carry", longint'(bus.err_trfc_o), 0);

    // Coincident tick and refresh; ready low holds debt at 0 and keeps errors
    do_reset();
    nop(TREFI - 1);
    chk("pre_tick_debt1", debt_of(1), 0);
    cyc(1'b1, 2'b11, 2'b10, C_REF);
    chk("coincident_debt0", debt_of(0), 0);
    chk("coincident_debt1", debt_of(1), 1);
    chk("coincident_count", longint'(bus.ref_count_o), 1);
    cyc(1'b1, 2'b11, 2'b10, C_ACT);
    chk("ready_err_set", longint'(bus.err_trfc_o), 1);
    nop(2 * TREFI - 1);
    chk("debt1_plus3", debt_of(1), 3);
    chk("debt0_plus2", debt_of(0), 2);
    for (int i = 0; i < 50; i++) cyc(1'b0, 2'b11, 2'b00, C_REF);
    chk("notready_debt0", debt_of(0), 0);
    chk("notready_debt1", debt_of(1), 0);
    chk("notready_err_kept", longint'(bus.err_trfc_o), 1);
    chk("notready_count_kept", longint'(bus.ref_count_o), 1);
    nop(TREFI - 1);
    chk("reready_no_early_tick", debt_of(1), 0);
    nop(1);
    chk("reready_first_tick0", debt_of(0), 1);
    chk("reready_first_tick1", debt_of(1), 1);

    // Starvation: rank 1 never refreshed for 9 ticks, rank 0 refreshed each interval
    do_reset();
    for (int n = 0; n < 9 * TREFI - 1; n++) begin
      if (n >= TREFI && (n % TREFI) == 100) cyc(1'b1, 2'b11, 2'b10, C_REF);
      else                                  cyc(1'b1, 2'b11, 2'b11, C_NOP);
    end
    chk("starve_pre_debt1", debt_of(1), 8);
    chk("starve_pre_flag", longint'(bus.err_starve_o), 0);
    nop(1);
    chk("starve_debt1", debt_of(1), 9);
    chk("starve_flag", longint'(bus.err_starve_o), 2);
    chk("starve_debt0", debt_of(0), 1);
    nop(TREFI);
    chk("starve_saturate", debt_of(1), 9);
    chk("starve_sticky", longint'(bus.err_starve_o), 2);

    // Pull-in: 9 refreshes on rank 0, 200 cycles apart, before the first tick
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'b11, 2'b10, C_REF);
      nop(199);
    end
    chk("pullin_pre_debt0", debt_of(0), -8);
    chk("pullin_pre_flag", longint'(bus.err_pullin_o), 0);
    cyc(1'b1, 2'b11, 2'b10, C_REF);
    chk("pullin_debt0", debt_of(0), -8);
    chk("pullin_flag", longint'(bus.err_pullin_o), 1);
    chk("pullin_count", longint'(bus.ref_count_o), 9);
    chk("pullin_no_trfc", longint'(bus.err_trfc_o), 0);

    // Steady state: both ranks refreshed once per interval for 20 intervals
    do_reset();
    bad = 0;
    for (int n = 0; n < 21 * TREFI; n++) begin
      if (n >= TREFI && (n % TREFI) == 100) cyc(1'b1, 2'b11, 2'b00, C_REF);
      else                                  cyc(1'b1, 2'b11, 2'b11, C_NOP);
      if (debt_of(0) < 0 || debt_of(0) > 1 || debt_of(1) < 0 || debt_of(1) > 1) bad++;
    end
    chk("steady_debt_range", bad, 0);
    chk("steady_debt0", debt_of(0), 1);
    chk("steady_debt1", debt_of(1), 1);
    chk("steady_count", longint'(bus.ref_count_o), 40);
    chk("steady_errors",
        longint'({bus.err_starve_o, bus.err_pullin_o, bus.err_trfc_o}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr2_multirank_refresh_monitor.md
DDR2_MULTIRANK_REFRESH_MONITOR -- requirements
Module: ddr2_multirank_refresh_monitor

Interface
REQ-001 Parameter NUM_RANKS, default 2, number of chip-select ranks monitored (1..4).
REQ-002 Parameter TREFI_CLK, default 7800, refresh credit interval in clk cycles (>=16).
REQ-003 Parameter TRFC_CLK, default 105, minimum cycles from AUTO REFRESH to the next non-NOP command on the same rank.
REQ-004 Parameter MAX_POSTPONE, default 8, maximum outstanding (owed) refreshes per rank.
REQ-005 Parameter MAX_PULLIN, default 8, maximum refreshes issued ahead of schedule per rank.
REQ-006 clk  in  1  controller clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 ready_i  in  1  controller ready; monitoring enabled only while high.
REQ-009 cke_pad  in  NUM_RANKS  per-rank clock enable.
REQ-010 csbar_pad  in  NUM_RANKS  per-rank chip select, active low.
REQ-011 rasbar_pad, casbar_pad, webar_pad  in  1 each  shared command pins.
REQ-012 debt_o  out  NUM_RANKS*5  per-rank signed two's-complement refresh debt, rank r at bits [5r+4:5r].
REQ-013 err_starve_o  out  NUM_RANKS  sticky: debt exceeded MAX_POSTPONE.
REQ-014 err_pullin_o  out  NUM_RANKS  sticky: refresh issued with debt already at -MAX_PULLIN.
REQ-015 err_trfc_o  out  NUM_RANKS  sticky: non-NOP command inside tRFC window.
REQ-016 ref_count_o  out  32  total AUTO REFRESH commands accepted across all ranks, wraps at 2^32.

Function
REQ-017 Refresh decode per rank r: cke_pad[r] & !csbar_pad[r] & !rasbar_pad & !casbar_pad & webar_pad; several ranks may refresh in the same cycle.
REQ-018 Non-NOP command on rank r: !csbar_pad[r] and {rasbar,casbar,webar} != 3'b111.
REQ-019 A single interval counter counts 0..TREFI_CLK-1 while ready_i is high; wrapping to 0 generates a one-cycle tick to all ranks.
REQ-020 Per rank, debt increments on tick and decrements on refresh; tick and refresh in the same cycle leave debt unchanged.
REQ-021 Debt saturates at +MAX_POSTPONE+1 and -MAX_PULLIN; values beyond are never stored.
REQ-022 err_starve_o[r] sets in the cycle after debt becomes MAX_POSTPONE+1.
REQ-023 err_pullin_o[r] sets in the cycle after a refresh arrives with debt == -MAX_PULLIN and no coincident tick; debt stays at -MAX_PULLIN.
REQ-024 Per rank, a tRFC down-counter loads TRFC_CLK-1 on refresh and decrements to 0; a non-NOP command (including another refresh) while counter != 0 sets err_trfc_o[r] in the next cycle; a command on the cycle the counter reaches 0 is legal.
REQ-025 A refresh flagged as a tRFC violation still updates debt and reloads the tRFC counter.
REQ-026 ref_count_o increments by the number of ranks refreshing in that cycle (popcount).
REQ-027 While ready_i is low: interval counter, debts, and tRFC counters are held at 0; error flags and ref_count_o are retained; commands are ignored.
REQ-028 On ready_i rising, the interval counter restarts from 0, so the first tick occurs TREFI_CLK cycles later.
REQ-029 Error flags are sticky until reset; no $fatal inside the block, the bench decides.
REQ-030 All outputs are registered; latency from command pins to any output change is exactly one cycle.

Reset
REQ-031 On reset, all debts, counters, error flags, and ref_count_o clear to 0, overriding ready_i and all pin activity in that cycle.
REQ-032 Reset asserted mid-tRFC window or with nonzero debt discards that state; there is no carry-over.

Structure
REQ-033 Package ddr2_refresh_pkg holds command-decode constants (NOP, REF encodings), DEBT_W=5, and the debt saturation helper function.
REQ-034 One sub-module, ddr2_refresh_rank_tracker, instantiated NUM_RANKS times, owns debt, tRFC counter, and the three error flags for one rank; the top owns the interval counter and ref_count_o.

Verification
REQ-035 Refresh each rank once per 7800-cycle tick for 20 intervals -> debt_o stays in {0,+1}, no errors, ref_count_o=40 (NUM_RANKS=2).
REQ-036 Suppress refreshes on rank 1 for 9 ticks -> err_starve_o=2'b10 one cycle after the 9th tick, and rank 1 debt reads +9.
REQ-037 Issue 9 refreshes on rank 0 spaced 200 cycles apart, immediately after ready -> err_pullin_o[0] sets after the 9th; debt reads -8.
REQ-038 Refresh rank 0, then ACTIVATE rank 0 at +104 cycles -> err_trfc_o[0]=1; repeat at +105 cycles after reset -> no error; ACTIVATE on rank 1 at +10 -> no error.
REQ-039 Refresh coincident with tick -> debt unchanged; deassert ready_i for 50 cycles with debt +3 -> debt 0, errors retained, first tick TREFI_CLK cycles after re-ready.
REQ-040 Assert reset during an active tRFC window with err_trfc_o set -> all outputs 0 next cycle.
